// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the memory-controller state encoding and default timeout.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [14:0] lc3b_pmem_addr;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP
  } lc3b_memctrl_state;

  localparam int unsigned LC3B_MEMCTRL_TIMEOUT = 255;

endpackage

// File: rtl/lc3b_mem_wbuf.sv
// One-entry posted-write buffer: loads a write, holds it until the drain is accepted or abandoned.
module lc3b_mem_wbuf
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [14:0] load_addr,
  input  logic [15:0] load_data,
  input  logic [1:0]  load_be,
  input  logic        drain_done,
  output logic        valid,
  output logic [14:0] addr,
  output logic [15:0] data,
  output logic [1:0]  be
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      be    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
      be    <= load_be;
    end else if (drain_done) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b CPU memory port to req/ready + rvalid backend bridge with timeout watchdog.
// Define LC3B_MEMCTRL_POSTED_WRITE_EN to enable the one-entry posted-write buffer.
module lc3b_mem_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LC3B_MEMCTRL_TIMEOUT,
  parameter logic [15:0] ERR_RDATA      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        pmem_req,
  output logic        pmem_we,
  output logic [14:0] pmem_addr,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_be,
  input  logic        pmem_ready,
  input  logic        pmem_rvalid,
  input  logic [15:0] pmem_rdata,
  output logic        err
);

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  lc3b_memctrl_state state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        resp_reg, resp_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [14:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [1:0]  be_reg, be_next;
  logic        err_reg, err_next;
  logic        timed_out;
  logic        wb_busy;

`ifdef LC3B_MEMCTRL_POSTED_WRITE_EN
  logic        wb_load, wb_done, wb_valid;
  logic [14:0] wb_addr;
  logic [15:0] wb_data;
  logic [1:0]  wb_be;

  lc3b_mem_wbuf u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (wb_load),
    .load_addr  (mem_address[15:1]),
    .load_data  (mem_wdata),
    .load_be    (mem_byte_enable),
    .drain_done (wb_done),
    .valid      (wb_valid),
    .addr       (wb_addr),
    .data       (wb_data),
    .be         (wb_be)
  );

  // The FSM never requests while the buffer is full, so the buffer owns the bus then.
  assign wb_busy    = wb_valid;
  assign pmem_req   = req_reg | wb_valid;
  assign pmem_we    = wb_valid ? 1'b1 : we_reg;
  assign pmem_addr  = wb_valid ? wb_addr : addr_reg;
  assign pmem_wdata = wb_valid ? wb_data : wdata_reg;
  assign pmem_be    = wb_valid ? wb_be : be_reg;
`else
  assign wb_busy    = 1'b0;
  assign pmem_req   = req_reg;
  assign pmem_we    = we_reg;
  assign pmem_addr  = addr_reg;
  assign pmem_wdata = wdata_reg;
  assign pmem_be    = be_reg;
`endif

  assign mem_resp  = resp_reg;
  assign mem_rdata = rdata_reg;
  assign err       = err_reg;
  assign timed_out = (cnt_reg == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= 2'b00;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      resp_reg  <= resp_next;
      rdata_reg <= rdata_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    resp_next  = 1'b0;
    rdata_next = rdata_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    err_next   = err_reg;
`ifdef LC3B_MEMCTRL_POSTED_WRITE_EN
    wb_load    = 1'b0;
    wb_done    = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if ((mem_read || mem_write) && !wb_busy) begin
          addr_next  = mem_address[15:1];
          wdata_next = mem_wdata;
          if (mem_write) begin
            we_next = 1'b1;
            be_next = mem_byte_enable;
            if (mem_byte_enable == 2'b00) begin
              state_next = RESP;
              resp_next  = 1'b1;
            end
`ifdef LC3B_MEMCTRL_POSTED_WRITE_EN
            else begin
              wb_load    = 1'b1;
              state_next = RESP;
              resp_next  = 1'b1;
            end
`else
            else begin
              state_next = REQ;
              req_next   = 1'b1;
              cnt_next   = '0;
            end
`endif
          end else begin
            we_next    = 1'b0;
            be_next    = 2'b11;
            state_next = REQ;
            req_next   = 1'b1;
            cnt_next   = '0;
          end
        end
      end
      REQ: begin
        // Accept wins over a timeout landing in the same cycle.
        if (pmem_ready) begin
          req_next   = 1'b0;
          cnt_next   = '0;
          state_next = we_reg ? RESP : WAIT_R;
          resp_next  = we_reg;
        end else if (timed_out) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = RESP;
          resp_next  = 1'b1;
          if (!we_reg) rdata_next = ERR_RDATA;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      WAIT_R: begin
        if (pmem_rvalid) begin
          rdata_next = pmem_rdata;
          state_next = RESP;
          resp_next  = 1'b1;
        end else if (timed_out) begin
          err_next   = 1'b1;
          rdata_next = ERR_RDATA;
          state_next = RESP;
          resp_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef LC3B_MEMCTRL_POSTED_WRITE_EN
    // The drain shares the watchdog; it only runs while the FSM is in IDLE/RESP.
    if (wb_load) begin
      cnt_next = '0;
    end else if (wb_valid) begin
      if (pmem_ready) begin
        wb_done  = 1'b1;
        cnt_next = '0;
      end else if (timed_out) begin
        wb_done  = 1'b1;
        err_next = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 16'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Scoreboard bench for lc3b_mem_ctrl with a configurable ready/rvalid backend model.
module tb_lc3b_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        pmem_req, pmem_we;
  logic [14:0] pmem_addr;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_be;
  logic        pmem_ready, pmem_rvalid;
  logic [15:0] pmem_rdata;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          be_ready_dly = 0;
  int          be_rvalid_dly = 1;
  bit          be_never = 1'b0;
  logic [15:0] be_rdata = 16'h0000;
  int          inject_cyc = -1;

  typedef struct {
    string       tag;
    bit          rd;
    bit          fields;
    logic [15:0] rdata;
    bit          err;
    int          lat;
    int          reqc;
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          n;
  } exp_t;
  exp_t sb[$];

  lc3b_mem_ctrl #(.TIMEOUT_CYCLES(8), .ERR_RDATA(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_req(pmem_req), .pmem_we(pmem_we), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_be(pmem_be),
    .pmem_ready(pmem_ready), .pmem_rvalid(pmem_rvalid), .pmem_rdata(pmem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backend: ready after be_ready_dly request cycles, rvalid be_rvalid_dly cycles after accept.
  initial begin : backend
    int wait_cnt;
    int rv_cnt;
    wait_cnt = 0;
    rv_cnt = 0;
    pmem_ready = 1'b0;
    pmem_rvalid = 1'b0;
    pmem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      pmem_ready = 1'b0;
      pmem_rvalid = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
        rv_cnt = 0;
      end else begin
        if (rv_cnt == 1) begin
          pmem_rvalid = 1'b1;
          pmem_rdata = be_rdata;
          rv_cnt = 0;
        end else if (rv_cnt > 1) begin
          rv_cnt--;
        end
        if (cyc == inject_cyc) begin
          pmem_rvalid = 1'b1;
          pmem_rdata = 16'h5555;
        end
        if (pmem_req && !be_never) begin
          if (wait_cnt == be_ready_dly) begin
            pmem_ready = 1'b1;
            wait_cnt = 0;
            if (!pmem_we) rv_cnt = be_rvalid_dly;
          end else begin
            wait_cnt++;
          end
        end else if (!pmem_req) begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    int reqc;
    bit prev_resp;
    exp_t e;
    reqc = 0;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reqc = 0;
        prev_resp = 1'b0;
      end else begin
        if (pmem_req) begin
          if (reqc == 0 && sb.size() > 0 && sb[0].fields) begin
            check({sb[0].tag, "_addr"}, 32'(pmem_addr), 32'(sb[0].addr));
            check({sb[0].tag, "_be"}, 32'(pmem_be), 32'(sb[0].be));
            check({sb[0].tag, "_we"}, 32'(pmem_we), 32'(!sb[0].rd));
            if (!sb[0].rd) check({sb[0].tag, "_wdata"}, 32'(pmem_wdata), 32'(sb[0].wdata));
          end
          reqc++;
        end
        if (mem_resp) begin
          check("resp_pulse", 32'(prev_resp), 32'd0);
          if (sb.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.tag, "_lat"}, 32'(cyc - e.n), 32'(e.lat));
            check({e.tag, "_err"}, 32'(err), 32'(e.err));
            if (e.reqc >= 0) check({e.tag, "_reqc"}, 32'(reqc), 32'(e.reqc));
            if (e.rd) check({e.tag, "_rdata"}, 32'(mem_rdata), 32'(e.rdata));
            $display("txn %s rd=%0d lat=%0d reqc=%0d rdata=%h err=%0d", e.tag, e.rd, cyc - e.n, reqc, mem_rdata, err);
          end
          reqc = 0;
        end
        prev_resp = mem_resp;
      end
    end
  end

  task automatic do_txn(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input int rdly, input int vdly, input bit never, input logic [15:0] rdata,
                        input bit fields, input bit exp_err, input int lat, input int reqc);
    exp_t e;
    int budget;
    @(negedge clk);
    be_ready_dly = rdly;
    be_rvalid_dly = vdly;
    be_never = never;
    be_rdata = rdata;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    mem_write = wr;
    mem_read = !wr;
    e.tag = tag; e.rd = !wr; e.fields = fields; e.rdata = rdata; e.err = exp_err;
    e.lat = lat; e.reqc = reqc; e.addr = addr[15:1]; e.be = wr ? be : 2'b11;
    e.wdata = wdata; e.n = cyc;
    sb.push_back(e);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!mem_resp && budget < 100);
    if (!mem_resp) check({tag, "_no_resp"}, 32'd0, 32'd1);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address = 16'h0000;
    mem_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_resp", 32'(mem_resp), 32'd0);
    check("rst_req", 32'(pmem_req), 32'd0);
    check("rst_we", 32'(pmem_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(mem_rdata), 32'd0);
    check("rst_addr", 32'(pmem_addr), 32'd0);
    check("rst_wdata", 32'(pmem_wdata), 32'd0);
    check("rst_be", 32'(pmem_be), 32'd0);
    rst_n = 1'b1;

    do_txn("rd0", 1'b0, 16'h3006, 16'h0000, 2'b11, 0, 1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 3, 1);
`ifndef LC3B_MEMCTRL_POSTED_WRITE_EN
    do_txn("wr0", 1'b1, 16'h1234, 16'hC0DE, 2'b11, 0, 1, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 1);
    do_txn("wrb", 1'b1, 16'h0011, 16'hAB00, 2'b10, 4, 1, 1'b0, 16'h0000, 1'b1, 1'b0, 6, 5);
`else
    do_txn("pwr", 1'b1, 16'h0400, 16'h1111, 2'b11, 2, 1, 1'b0, 16'h0000, 1'b0, 1'b0, 1, -1);
    do_txn("prd", 1'b0, 16'h0402, 16'h0000, 2'b11, 2, 1, 1'b0, 16'h7777, 1'b0, 1'b0, 7, -1);
`endif
    do_txn("noop", 1'b1, 16'h0020, 16'hFFFF, 2'b00, 0, 1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0);

    // rvalid during REQ is a protocol violation and must not be captured.
    inject_cyc = cyc + 2;
    do_txn("rdvio", 1'b0, 16'h0100, 16'h0000, 2'b11, 2, 1, 1'b0, 16'hCAFE, 1'b1, 1'b0, 5, 3);

    do_txn("rdto", 1'b0, 16'h2000, 16'h0000, 2'b11, 0, 1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 9, 8);
    inject_cyc = cyc + 1;
    repeat (3) @(negedge clk);
    check("late_rvalid_rdata", 32'(mem_rdata), 32'h0000DEAD);
    check("late_rvalid_err", 32'(err), 32'd1);

    // Reset while waiting for rvalid.
    @(negedge clk);
    be_ready_dly = 0; be_rvalid_dly = 20; be_never = 1'b0;
    mem_address = 16'h0040; mem_read = 1'b1; mem_write = 1'b0;
    n = cyc;
    repeat (3) @(negedge clk);
    check("midop_in_wait", 32'(cyc - n), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midop_req", 32'(pmem_req), 32'd0);
    check("midop_resp", 32'(mem_resp), 32'd0);
    check("midop_err", 32'(err), 32'd0);
    sb.delete();
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_txn("rdpost", 1'b0, 16'h7FFE, 16'h0000, 2'b11, 0, 1, 1'b0, 16'h1234, 1'b1, 1'b0, 3, 1);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
